// File: rtl/elastic_pipeline_regs.sv
// Elastic relay-station chain: N_STAGES main+skid register pairs with valid/ready handshake,
// registered ready at every stage boundary, synchronous flush and a running occupancy count.
module elastic_pipeline_regs #(
  parameter int unsigned WIDTH    = 6,
  parameter int unsigned N_STAGES = 1,
  localparam int unsigned CNT_W   = (N_STAGES == 0) ? 1 : $clog2(2 * N_STAGES + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_valid,
  output logic             o_ready,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  input  logic             i_ready,
  input  logic             i_flush,
  output logic [CNT_W-1:0] o_count
);

  if (N_STAGES == 0) begin : g_wire
    assign o_data  = i_data;
    assign o_valid = i_valid;
    assign o_ready = i_ready;
    assign o_count = '0;

    logic unused_wire;
    assign unused_wire = ^{clk, reset_n, i_flush};
  end else begin : g_pipe
    logic [N_STAGES-1:0] m_valid_q, m_valid_d;
    logic [N_STAGES-1:0] s_valid_q, s_valid_d;
    logic [WIDTH-1:0]    m_data_q [N_STAGES];
    logic [WIDTH-1:0]    s_data_q [N_STAGES];
    logic [N_STAGES-1:0] m_load, s_load, m_pop_skid;

    logic [N_STAGES-1:0] in_valid, out_ready;
    logic [WIDTH-1:0]    in_data [N_STAGES];

    logic [CNT_W-1:0]    count_q, count_d;
    logic                up_xfer, dn_xfer;

    // Stage k consumes stage k-1's main register; ready back to k-1 is k's registered !skid.
    assign in_valid[0]           = i_valid;
    assign in_data[0]            = i_data;
    assign out_ready[N_STAGES-1] = i_ready;
    for (genvar k = 1; k < N_STAGES; k++) begin : g_link
      assign in_valid[k]    = m_valid_q[k-1];
      assign in_data[k]     = m_data_q[k-1];
      assign out_ready[k-1] = ~s_valid_q[k];
    end

    always_comb begin
      logic st_in, st_out;
      m_valid_d  = m_valid_q;
      s_valid_d  = s_valid_q;
      m_load     = '0;
      s_load     = '0;
      m_pop_skid = '0;
      st_in      = 1'b0;
      st_out     = 1'b0;
      for (int k = 0; k < N_STAGES; k++) begin
        st_in  = in_valid[k] && !s_valid_q[k];
        st_out = m_valid_q[k] && out_ready[k];
        case ({m_valid_q[k], s_valid_q[k]})
          2'b00: begin
            if (st_in) begin
              m_valid_d[k] = 1'b1;
              m_load[k]    = 1'b1;
            end
          end
          2'b10: begin
            if (st_in && !st_out) begin
              s_valid_d[k] = 1'b1;
              s_load[k]    = 1'b1;
            end else if (st_in && st_out) begin
              m_load[k] = 1'b1;
            end else if (st_out) begin
              m_valid_d[k] = 1'b0;
            end
          end
          2'b11: begin
            if (st_out) begin
              s_valid_d[k]  = 1'b0;
              m_pop_skid[k] = 1'b1;
            end
          end
          default: ;
        endcase
      end
      if (i_flush) begin
        m_valid_d  = '0;
        s_valid_d  = '0;
        m_load     = '0;
        s_load     = '0;
        m_pop_skid = '0;
      end
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        m_valid_q <= '0;
        s_valid_q <= '0;
        for (int k = 0; k < N_STAGES; k++) begin
          m_data_q[k] <= '0;
          s_data_q[k] <= '0;
        end
      end else begin
        m_valid_q <= m_valid_d;
        s_valid_q <= s_valid_d;
        for (int k = 0; k < N_STAGES; k++) begin
          if (m_load[k]) begin
            m_data_q[k] <= in_data[k];
          end else if (m_pop_skid[k]) begin
            m_data_q[k] <= s_data_q[k];
          end
          if (s_load[k]) begin
            s_data_q[k] <= in_data[k];
          end
        end
      end
    end

    assign o_ready = ~s_valid_q[0];
    assign o_valid = m_valid_q[N_STAGES-1];
    assign o_data  = m_data_q[N_STAGES-1];

    assign up_xfer = i_valid && o_ready;
    assign dn_xfer = o_valid && i_ready;

    always_comb begin
      count_d = count_q;
      if (i_flush) begin
        count_d = '0;
      end else if (up_xfer && !dn_xfer) begin
        count_d = count_q + CNT_W'(1);
      end else if (!up_xfer && dn_xfer) begin
        count_d = count_q - CNT_W'(1);
      end
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        count_q <= '0;
      end else begin
        count_q <= count_d;
      end
    end

    assign o_count = count_q;

    a_no_orphan_skid: assert property (@(posedge clk) disable iff (!reset_n)
      (s_valid_q & ~m_valid_q) == '0);

    a_count_matches: assert property (@(posedge clk) disable iff (!reset_n)
      $countones({m_valid_q, s_valid_q}) == int'(count_q));
  end

endmodule

// File: tb/tb_elastic_pipeline_regs.sv
// Bench for elastic_pipeline_regs: four instances (3, 2, 1 and 0 stages) checked against a
// FIFO-queue scoreboard every cycle plus directed scenarios with literal expectations.
module tb_elastic_pipeline_regs;

  localparam int NS [4] = '{3, 2, 1, 0};

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] din  [4];
  logic       vin  [4];
  logic       rin  [4];
  logic       fl   [4];
  logic [7:0] dout [4];
  logic       vout [4];
  logic       rout [4];
  logic [2:0] c0;
  logic [2:0] c1;
  logic [1:0] c2;
  logic [0:0] c3;
  logic [7:0] cnt  [4];

  assign cnt[0] = {5'd0, c0};
  assign cnt[1] = {5'd0, c1};
  assign cnt[2] = {6'd0, c2};
  assign cnt[3] = {7'd0, c3};

  always #5 clk = ~clk;

  elastic_pipeline_regs #(.WIDTH(8), .N_STAGES(3)) u_dut3 (
    .clk(clk), .reset_n(reset_n), .i_data(din[0]), .i_valid(vin[0]), .o_ready(rout[0]),
    .o_data(dout[0]), .o_valid(vout[0]), .i_ready(rin[0]), .i_flush(fl[0]), .o_count(c0));
  elastic_pipeline_regs #(.WIDTH(8), .N_STAGES(2)) u_dut2 (
    .clk(clk), .reset_n(reset_n), .i_data(din[1]), .i_valid(vin[1]), .o_ready(rout[1]),
    .o_data(dout[1]), .o_valid(vout[1]), .i_ready(rin[1]), .i_flush(fl[1]), .o_count(c1));
  elastic_pipeline_regs #(.WIDTH(8), .N_STAGES(1)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .i_data(din[2]), .i_valid(vin[2]), .o_ready(rout[2]),
    .o_data(dout[2]), .o_valid(vout[2]), .i_ready(rin[2]), .i_flush(fl[2]), .o_count(c2));
  elastic_pipeline_regs #(.WIDTH(8), .N_STAGES(0)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .i_data(din[3]), .i_valid(vin[3]), .o_ready(rout[3]),
    .o_data(dout[3]), .o_valid(vout[3]), .i_ready(rin[3]), .i_flush(fl[3]), .o_count(c3));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act_v, input int exp_v);
    checks++;
    if (act_v != exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act_v, exp_v, $time);
    end
  endtask

  // Scoreboard: the block is a FIFO of capacity 2*N; only the active instance is tracked.
  int         act = 3;
  logic [7:0] mq [$];
  logic [7:0] exp_b;

  always @(negedge reset_n) mq.delete();

  always @(negedge clk) begin
    if (!reset_n) begin
      mq.delete();
    end else if (act < 3) begin
      chk("model_count", int'(cnt[act]), mq.size());
      if (rout[act]) chk("ready_below_capacity", int'(mq.size() < 2 * NS[act]), 1);
      if (vout[act]) chk("valid_nonempty", int'(mq.size() > 0), 1);
      if (vout[act] && rin[act]) begin
        if (mq.size() == 0) begin
          chk("pop_from_empty", 0, 1);
        end else begin
          exp_b = mq.pop_front();
          chk("model_data", int'(dout[act]), int'(exp_b));
        end
      end
      if (fl[act]) mq.delete();
      else if (vin[act] && rout[act]) mq.push_back(din[act]);
    end
  end

  task automatic do_reset(input int which);
    act = which;
    for (int d = 0; d < 4; d++) begin
      din[d] = '0; vin[d] = 1'b0; rin[d] = 1'b0; fl[d] = 1'b0;
    end
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int         i, peak;
    logic       r0, seen;
    logic [7:0] outs [$];
    logic [7:0] sent [20];
    logic [7:0] t6_d [4];
    logic       t6_v [4];
    logic       t6_r [4];

    // 1: three stages, free-flowing sink, latency 3, one beat per cycle
    do_reset(0);
    rin[0] = 1'b1;
    peak = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      vin[0] = (k < 5);
      din[0] = 8'(k + 1);
      #2;
      chk("t1_valid", int'(vout[0]), int'(k >= 3 && k <= 7));
      if (k >= 3 && k <= 7) chk("t1_data", int'(dout[0]), k - 2);
      chk("t1_ready", int'(rout[0]), 1);
      if (int'(cnt[0]) > peak) peak = int'(cnt[0]);
    end
    chk("t1_peak_count", peak, 3);

    // 2: two stages, stalled sink absorbs exactly four beats, then drains in order
    do_reset(1);
    i = 1;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      din[1] = 8'(i); vin[1] = (i <= 6);
      #2;
      if (vin[1] && rout[1]) i++;
    end
    chk("t2_accepted", i - 1, 4);
    chk("t2_ready_low", int'(rout[1]), 0);
    chk("t2_count_full", int'(cnt[1]), 4);
    outs.delete();
    for (int k = 0; k < 30 && outs.size() < 6; k++) begin
      @(posedge clk); #1;
      rin[1] = 1'b1; din[1] = 8'(i); vin[1] = (i <= 6);
      #2;
      if (vin[1] && rout[1]) i++;
      if (vout[1] && rin[1]) outs.push_back(dout[1]);
    end
    chk("t2_nout", outs.size(), 6);
    for (int j = 0; j < outs.size(); j++) chk("t2_order", int'(outs[j]), j + 1);

    // 3: two stages, sink toggling, 20 random beats; ready must not follow i_ready
    do_reset(1);
    for (int j = 0; j < 20; j++) sent[j] = 8'($urandom_range(0, 255));
    i = 0;
    outs.delete();
    for (int k = 0; k < 120 && outs.size() < 20; k++) begin
      @(posedge clk); #1;
      rin[1] = (k % 2 == 0);
      vin[1] = (i < 20);
      din[1] = (i < 20) ? sent[i] : 8'd0;
      #1;
      r0 = rout[1];
      rin[1] = !rin[1];
      #1;
      chk("t3_ready_not_comb", int'(rout[1]), int'(r0));
      rin[1] = !rin[1];
      #1;
      if (vin[1] && rout[1]) i++;
      if (vout[1] && rin[1]) outs.push_back(dout[1]);
    end
    chk("t3_nout", outs.size(), 20);
    for (int j = 0; j < outs.size(); j++) chk("t3_order", int'(outs[j]), int'(sent[j]));

    // 4: three stages, flush with a simultaneous new beat discards everything
    do_reset(0);
    i = 0;
    for (int k = 0; k < 10 && i < 4; k++) begin
      @(posedge clk); #1;
      din[0] = 8'h10 + 8'(i); vin[0] = 1'b1;
      #2;
      if (rout[0]) i++;
    end
    @(posedge clk); #1;
    din[0] = 8'hAA; vin[0] = 1'b1; fl[0] = 1'b1;
    #2;
    chk("t4_count_before_flush", int'(cnt[0]), 4);
    @(posedge clk); #1;
    fl[0] = 1'b0; vin[0] = 1'b0;
    #2;
    chk("t4_valid_after_flush", int'(vout[0]), 0);
    chk("t4_count_after_flush", int'(cnt[0]), 0);
    chk("t4_ready_after_flush", int'(rout[0]), 1);
    rin[0] = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #3;
      if (vout[0]) seen = 1'b1;
    end
    chk("t4_no_beat_after_flush", int'(seen), 0);

    // 5: one stage, asynchronous reset pulse while full, then a fresh beat
    do_reset(2);
    i = 0;
    for (int k = 0; k < 10 && i < 2; k++) begin
      @(posedge clk); #1;
      din[2] = 8'h21 + 8'(i); vin[2] = 1'b1;
      #2;
      if (rout[2]) i++;
    end
    @(posedge clk); #1;
    vin[2] = 1'b0;
    #1;
    chk("t5_count_before_reset", int'(cnt[2]), 2);
    reset_n = 1'b0;
    #1;
    chk("t5_valid_in_reset", int'(vout[2]), 0);
    chk("t5_data_in_reset", int'(dout[2]), 0);
    chk("t5_count_in_reset", int'(cnt[2]), 0);
    chk("t5_ready_in_reset", int'(rout[2]), 1);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;
    din[2] = 8'h3F; vin[2] = 1'b1; rin[2] = 1'b1;
    #2;
    chk("t5_accept_ready", int'(rout[2]), 1);
    @(posedge clk); #1;
    vin[2] = 1'b0;
    #2;
    chk("t5_valid_after_1", int'(vout[2]), 1);
    chk("t5_data_after_1", int'(dout[2]), 8'h3F);

    // 6: zero stages is a pure wire
    act = 3;
    t6_d = '{8'h5A, 8'hC3, 8'hFF, 8'h00};
    t6_v = '{1'b1, 1'b0, 1'b1, 1'b0};
    t6_r = '{1'b0, 1'b1, 1'b1, 1'b0};
    for (int j = 0; j < 4; j++) begin
      din[3] = t6_d[j]; vin[3] = t6_v[j]; rin[3] = t6_r[j]; fl[3] = (j == 2);
      #1;
      chk("t6_data", int'(dout[3]), int'(t6_d[j]));
      chk("t6_valid", int'(vout[3]), int'(t6_v[j]));
      chk("t6_ready", int'(rout[3]), int'(t6_r[j]));
      chk("t6_count", int'(cnt[3]), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
